// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB3 completer holding four student-info registers, a
// read-only STATUS word (write/read completion counters) and a read-only ID.
// Every transfer is stretched by WAIT_STATES access cycles before PREADY.
//
// Ports:
//   PCLK     clock, rising edge
//   PRESET   asynchronous active-low reset
//   PSEL     completer select
//   PENABLE  access-phase strobe
//   PWRITE   1 = write, 0 = read
//   PADDR    byte address (offset in [7:0], upper bits must be zero)
//   PWDATA   write data, sampled in the setup phase
//   PSTRB    byte-lane write strobes (only with APB_WAIT_SLAVE_PSTRB_EN)
//   PRDATA   read data, non-zero only on an error-free read completion
//   PREADY   transfer completes this cycle
//   PSLVERR  transfer error, qualified by PREADY
//
// Optional feature macro: APB_WAIT_SLAVE_PSTRB_EN adds the PSTRB port.
// Default build has no PSTRB and every write updates the full word.
//
// Map: 0x00 number_in_group, 0x04 date, 0x08 surname, 0x0C name (RW),
//      0x10 STATUS {rd_cnt, wr_cnt} (RO), 0x14 ID (RO).

module apb_wait_slave #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
`ifdef APB_WAIT_SLAVE_PSTRB_EN
    input  logic [3:0]        PSTRB,
`endif
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned NUM_RW = 4;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_write;
    logic [DATA_W-1:0]   lat_wdata;
    logic [STRB_W-1:0]   lat_strb;
    logic [DATA_W-1:0]   rw_reg [NUM_RW];
    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W-1:0]    rd_cnt;
    logic                ready_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    // Strobes seen on the bus; without the feature every lane is written.
    logic [STRB_W-1:0]   bus_strb;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
    assign bus_strb = PSTRB;
`else
    assign bus_strb = {STRB_W{1'b1}};
`endif

    // Decode source: bus inputs while accepting a setup phase (zero-wait
    // case), latched transfer otherwise.
    logic [ADDR_W-1:0]   dec_addr;
    logic                dec_write;
    logic [7:0]          dec_off;
    logic                dec_err;
    logic [DATA_W-1:0]   dec_rdata;
    logic [DATA_W-1:0]   rdata_next;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
    logic [STRB_W-1:0]   dec_strb;
`endif

    always_comb begin
        dec_addr  = lat_addr;
        dec_write = lat_write;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
        dec_strb  = lat_strb;
`endif
        if (state == ST_IDLE) begin
            dec_addr  = PADDR;
            dec_write = PWRITE;
`ifdef APB_WAIT_SLAVE_PSTRB_EN
            dec_strb  = bus_strb;
`endif
        end

        dec_off = dec_addr[7:0];

        dec_err = 1'b0;
        if ((dec_addr >> 8) != '0) begin
            dec_err = 1'b1;
        end
        if (dec_off[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end
        if (dec_off > 8'h14) begin
            dec_err = 1'b1;
        end
        if (dec_write && (dec_off >= 8'h10)) begin
            dec_err = 1'b1;
        end
`ifdef APB_WAIT_SLAVE_PSTRB_EN
        if (!dec_write && (dec_strb != '0)) begin
            dec_err = 1'b1;
        end
`endif

        dec_rdata = '0;
        case (dec_off[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: dec_rdata = rw_reg[dec_off[3:2]];
            3'd4:                   dec_rdata = {rd_cnt, wr_cnt};
            3'd5:                   dec_rdata = ID_VALUE;
            default:                dec_rdata = '0;
        endcase

        rdata_next = (!dec_write && !dec_err) ? dec_rdata : '0;
    end

    // Byte-lane merge of latched write data into the old register value.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Transfer FSM, register file, counters and registered bus outputs.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                rw_reg[i] <= '0;
            end
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    // PENABLE without a prior setup phase is ignored here.
                    if (PSEL && !PENABLE) begin
                        lat_addr  <= PADDR;
                        lat_write <= PWRITE;
                        lat_wdata <= PWDATA;
                        lat_strb  <= bus_strb;
                        wait_cnt  <= WAIT_W'(WAIT_STATES);
                        state     <= ST_ACCESS;
                        if (WAIT_STATES == 0) begin
                            ready_q <= 1'b1;
                            err_q   <= dec_err;
                            rdata_q <= rdata_next;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (!PSEL) begin
                        // Abort: drop the transfer without side effects.
                        state   <= ST_IDLE;
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                    end else if (PENABLE) begin
                        if (ready_q) begin
                            if (!err_q) begin
                                if (lat_write) begin
                                    rw_reg[lat_addr[3:2]] <= merge_bytes(
                                        rw_reg[lat_addr[3:2]], lat_wdata, lat_strb);
                                    if (wr_cnt != {CNT_W{1'b1}}) begin
                                        wr_cnt <= wr_cnt + CNT_W'(1);
                                    end
                                end else begin
                                    if (rd_cnt != {CNT_W{1'b1}}) begin
                                        rd_cnt <= rd_cnt + CNT_W'(1);
                                    end
                                end
                            end
                            state   <= ST_IDLE;
                            ready_q <= 1'b0;
                            err_q   <= 1'b0;
                            rdata_q <= '0;
                        end else begin
                            wait_cnt <= wait_cnt - WAIT_W'(1);
                            // Last wait cycle: present the response next cycle.
                            if (wait_cnt == WAIT_W'(1)) begin
                                ready_q <= 1'b1;
                                err_q   <= dec_err;
                                rdata_q <= rdata_next;
                            end
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign PREADY  = ready_q;
    assign PSLVERR = err_q;
    assign PRDATA  = rdata_q;

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB3 completer (slave end of the APB link) with a programmable number of wait states and error signalling.
- Holds the four student-info registers (number_in_group, date, surname, name) plus a read-only status counter word and a read-only ID word.
- Connects directly to the PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY outputs and inputs of the existing APB master.

Parameters:
- ADDR_W, 32: width of PADDR.
- WAIT_STATES, 1: access-phase cycles inserted before PREADY; legal range 0..15.
- ID_VALUE, 32'hA9B0_0001: constant returned at offset 0x14.

Ports:
- PCLK  in  1  clock, all state on rising edge.
- PRESET  in  1  asynchronous, active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  transfer error, valid only while PREADY=1.

Behaviour:
- Reset (PRESET=0, asynchronous):
  - FSM goes to IDLE.
  - All four RW registers are cleared to 0, and both counters are cleared to 0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
- Register map (offset is PADDR[7:0]; PADDR[ADDR_W-1:8] must be 0):
  - 0x00 number_in_group, RW.
  - 0x04 date, RW.
  - 0x08 surname, RW.
  - 0x0C name, RW.
  - 0x10 STATUS, RO: [15:0] wr_cnt, [31:16] rd_cnt.
  - 0x14 ID, RO: ID_VALUE.
- Error decode (sets PSLVERR=1 on the completion cycle):
  - unmapped address,
  - PADDR[1:0] != 0,
  - any bit of PADDR[ADDR_W-1:8] set,
  - write to 0x10 or 0x14.
  - An errored write changes no state. An errored read returns PRDATA=0.
- FSM has two states, IDLE and ACCESS:
  - IDLE: on a rising edge with PSEL=1 and PENABLE=0 (setup phase):
    - latch PADDR, PWRITE and PWDATA;
    - load wait counter with WAIT_STATES;
    - go to ACCESS.
  - ACCESS: PREADY = (wait counter == 0), decoded from registered state only, never combinationally from bus inputs.
    - Each edge with PSEL=1, PENABLE=1 and PREADY=0 decrements the counter.
    - The completion edge (PSEL=1, PENABLE=1, PREADY=1) does three things: commits the write, updates the counters, and returns the FSM to IDLE.
  - Latency: PREADY is high in access cycle WAIT_STATES+1. A full transfer takes WAIT_STATES+2 cycles.
  - Back-to-back transfers: a setup phase arriving on the cycle after completion is accepted normally, with no idle cycle required.
- Output data rules:
  - PRDATA carries the selected register only while PREADY=1 with a latched read and no error; it is 0 otherwise.
  - PSLVERR is 0 whenever PREADY=0.
- Write data uses the PWDATA value latched in setup. A PWDATA change during the access phase is ignored.
- Counters:
  - wr_cnt increments on each error-free write completion; rd_cnt on each error-free read completion.
  - Both saturate at 16'hFFFF (no wrap).
  - A read of STATUS counts itself: the returned value is pre-increment.
- Abort: if PSEL=0 while in ACCESS before completion, the FSM returns to IDLE with no write and no counter update.
- Protocol violation: PENABLE=1 while in IDLE is ignored, and the FSM stays in IDLE.
- Reset during ACCESS: the FSM and all registers return to their reset values immediately, and the pending write is lost.

Optional Feature:
APB_WAIT_SLAVE_PSTRB_EN:
- Defined:
  - Adds port PSTRB in 4 (byte-lane write strobes), latched in setup.
  - A write updates only bytes whose strobe is 1. A write with PSTRB=4'b0000 completes without error and changes nothing except wr_cnt.
  - A read with PSTRB != 0 gives PSLVERR=1.
- Undefined: no PSTRB port, and every write updates the full 32-bit word.

Test Plan:
- WAIT_STATES=1: write 0x00=32'h17, 0x04=32'h15112023, 0x08=32'h4C594150, 0x0C=32'h56494B41, then read all four back -> each PREADY arrives in access cycle 2, PSLVERR=0, read data matches, STATUS=32'h0004_0004 read before the final STATUS increment.
- WAIT_STATES=0 and WAIT_STATES=3: read 0x14 -> PRDATA=32'hA9B0_0001 with PREADY in access cycle 1 and 4 respectively.
- Error cases:
  - write to 0x10 -> PSLVERR=1, wr_cnt unchanged;
  - read of 0x18 -> PSLVERR=1, PRDATA=0;
  - read of 0x02 -> PSLVERR=1, PRDATA=0.
- Abort: drop PSEL mid-wait during a write of 32'hDEADBEEF to 0x00 -> register keeps its old value, wr_cnt unchanged, next transfer behaves normally.
- Reset: assert PRESET=0 mid-access after 0x04 holds 32'h15112023 -> PREADY=0 immediately, and a post-reset read of 0x04 returns 0 and STATUS returns 0 (rd_cnt becomes 1 after that read).
- APB_WAIT_SLAVE_PSTRB_EN: 0x0C=32'h56494B41, then write 32'hFFFFFFFF with PSTRB=4'b0101 -> read returns 32'h56FF4BFF.
